// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle multiply/divide unit for the EX stage. Executes
//               mult, multu, div and divu into private HI/LO registers and
//               handles mthi/mtlo. The result is computed when the operation
//               is accepted, held, and committed when the busy counter
//               expires. The architectural timing is set by MULT_CYCLES and
//               DIV_CYCLES.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   synchronous active-high reset
//   start   in   1   issue strobe; md_op is sampled when start=1
//   md_op   in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                    5 mthi, 6 mtlo, 7 reserved (none)
//   a       in  32   rs operand (dividend / multiplicand / mthi-mtlo source)
//   b       in  32   rt operand (divisor / multiplier)
//   busy    out  1   high while a mult/div is in flight
//   hi_out  out 32   committed HI register
//   lo_out  out 32   committed LO register
// ============================================================================
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    logic [3:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic        r_res_we;

    logic               w_accept;
    logic               w_b_zero;
    logic               w_div_ovf;
    logic [31:0]        w_divisor;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_res_we;

    assign busy     = (r_count != 4'd0);
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;
    assign w_accept = start & ~busy;

    // Substituting a divisor of 1 keeps the dividers well defined for b=0
    // (result discarded anyway) and for the signed INT_MIN / -1 case, where
    // dividing by 1 yields exactly the required LO=0x80000000, HI=0.
    assign w_b_zero  = (b == 32'd0);
    assign w_div_ovf = (md_op == c_op_div) && (a == 32'h8000_0000) &&
                       (b == 32'hFFFF_FFFF);
    assign w_divisor = (w_b_zero || w_div_ovf) ? 32'd1 : b;

    assign w_smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_umul = {32'd0, a} * {32'd0, b};
    assign w_sq   = $signed(a) / $signed(w_divisor);
    assign w_sr   = $signed(a) % $signed(w_divisor);
    assign w_uq   = a / w_divisor;
    assign w_ur   = a % w_divisor;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_we = 1'b0;
        case (md_op)
            c_op_mult: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
                w_res_we = 1'b1;
            end
            c_op_multu: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
                w_res_we = 1'b1;
            end
            c_op_div: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
                w_res_we = ~w_b_zero;
            end
            c_op_divu: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
                w_res_we = ~w_b_zero;
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
                w_res_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 4'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_we <= 1'b0;
        end else if (busy) begin
            // Any start while busy is ignored; only the countdown advances.
            r_count <= r_count - 4'd1;
            if ((r_count == 4'd1) && r_res_we) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
        end else if (w_accept) begin
            case (md_op)
                c_op_mult, c_op_multu: begin
                    r_count  <= c_mult_cnt;
                    r_res_hi <= w_res_hi;
                    r_res_lo <= w_res_lo;
                    r_res_we <= w_res_we;
                end
                c_op_div, c_op_divu: begin
                    r_count  <= c_div_cnt;
                    r_res_hi <= w_res_hi;
                    r_res_lo <= w_res_lo;
                    r_res_we <= w_res_we;
                end
                c_op_mthi: r_hi <= a;
                c_op_mtlo: r_lo <= a;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit. Expected HI/LO pairs
//               are queued when an operation is issued and popped when the
//               unit drops busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    hilo_t       sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          tests;
    int          failed;

    mul_div_unit #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one accepted mult/div and queue its expected commit value.
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo);
        hilo_t e;
        start = 1'b1;
        md_op = op;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        e.hi  = ehi;
        e.lo  = elo;
        sb_q.push_back(e);
    endtask

    // Counts busy cycles (starting from 'already'), checks HI/LO hold, then
    // pops the scoreboard and checks the committed value.
    task automatic wait_commit(input string tag, input int exp_cycles, input int already);
        int    cnt;
        hilo_t e;
        cnt = already;
        while (busy === 1'b1 && cnt < 20) begin
            check({tag, "_hold_hi"}, hi_out, m_hi);
            check({tag, "_hold_lo"}, lo_out, m_lo);
            tick();
            cnt++;
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(exp_cycles));
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_hi"}, hi_out, e.hi);
            check({tag, "_lo"}, lo_out, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] av);
        start = 1'b1;
        md_op = op;
        a     = av;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        if (op == 3'd5) m_hi = av;
        if (op == 3'd6) m_lo = av;
        check("mt_busy", {31'd0, busy}, 32'd0);
        check("mt_hi", hi_out, m_hi);
        check("mt_lo", lo_out, m_lo);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] p;
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = 3'd0;
        a      = 32'd0;
        b      = 32'd0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);
        reset = 1'b0;
        tick();

        // mult / multu
        issue(3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_commit("mult", MULT_CYCLES, 0);
        issue(3'd2, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE);
        wait_commit("multu", MULT_CYCLES, 0);

        // mthi; busy must not rise afterwards either
        move_to(3'd5, 32'hDEAD_BEEF);
        tick();
        check("mthi_busy_later", {31'd0, busy}, 32'd0);

        // md_op 0 and 7 with start are no-ops
        move_to(3'd0, 32'h1111_1111);
        move_to(3'd7, 32'h2222_2222);

        // div / divu
        issue(3'd3, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_commit("div_neg", DIV_CYCLES, 0);
        issue(3'd4, 32'd7, 32'd2, 32'd1, 32'd3);
        wait_commit("divu", DIV_CYCLES, 0);

        // divide by zero leaves HI/LO untouched
        move_to(3'd5, 32'h0000_1234);
        move_to(3'd6, 32'h0000_5678);
        issue(3'd3, 32'd5, 32'd0, 32'h0000_1234, 32'h0000_5678);
        wait_commit("div0", DIV_CYCLES, 0);
        issue(3'd4, 32'd9, 32'd0, 32'h0000_1234, 32'h0000_5678);
        wait_commit("divu0", DIV_CYCLES, 0);

        // signed overflow
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        wait_commit("div_ovf", DIV_CYCLES, 0);

        // busy interlock: mtlo at busy cycle 2 and divu at cycle 3 ignored
        issue(3'd1, 32'd3, 32'd4, 32'd0, 32'd12);
        check("ilk_busy1", {31'd0, busy}, 32'd1);
        tick();
        start = 1'b1; md_op = 3'd6; a = 32'h1;
        tick();
        start = 1'b1; md_op = 3'd4; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0; md_op = 3'd0;
        wait_commit("ilk_mult", MULT_CYCLES, 3);
        check("ilk_lo_not_1", {31'd0, (lo_out == 32'h1)}, 32'd0);
        // accepted in the first idle cycle after commit
        issue(3'd4, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_commit("ilk_divu", DIV_CYCLES, 0);

        // randomized products and unsigned quotients against a small model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            p  = 64'(longint'(int'(ra)) * longint'(int'(rb)));
            issue(3'd1, ra, rb, p[63:32], p[31:0]);
            wait_commit("rnd_mult", MULT_CYCLES, 0);
            p  = {32'd0, ra} * {32'd0, rb};
            issue(3'd2, ra, rb, p[63:32], p[31:0]);
            wait_commit("rnd_multu", MULT_CYCLES, 0);
            if (rb == 32'd0) rb = 32'd3;
            rb = rb >> (i * 7);
            if (rb == 32'd0) rb = 32'd5;
            issue(3'd4, ra, rb, ra % rb, ra / rb);
            wait_commit("rnd_divu", DIV_CYCLES, 0);
        end

        // reset mid-operation: HI/LO nonzero before, reset at busy cycle 3
        check("pre_rst_nonzero", {31'd0, (hi_out != 32'd0 || lo_out != 32'd0)}, 32'd1);
        issue(3'd3, 32'd100, 32'd3, 32'd1, 32'd33);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb_q.pop_back());
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi_out, 32'd0);
        check("rst_mid_lo", lo_out, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("rst_no_commit_busy", {31'd0, busy}, 32'd0);
        check("rst_no_commit_hi", hi_out, 32'd0);
        check("rst_no_commit_lo", lo_out, 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
